// File: rtl/neander_control.sv
// rtl/neander_control.sv - Neander CPU control FSM with memory req/ack watchdog
// Define NEANDER_CTRL_SUB_EN to decode opcode 7 as SUB (ula_op=5).
module neander_control #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_opcode,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_mem_ack,
  input  logic       i_run,
  output logic       o_pc_inc,
  output logic       o_pc_load,
  output logic       o_mar_sel,
  output logic       o_mar_load,
  output logic       o_rdm_load,
  output logic       o_ri_load,
  output logic       o_ac_load,
  output logic       o_nz_load,
  output logic [2:0] o_ula_op,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_halted,
  output logic       o_bus_err
);

  localparam logic [3:0] S_FETCH_A = 4'd0;
  localparam logic [3:0] S_FETCH_B = 4'd1;
  localparam logic [3:0] S_FETCH_C = 4'd2;
  localparam logic [3:0] S_DECODE  = 4'd3;
  localparam logic [3:0] S_OPND    = 4'd4;
  localparam logic [3:0] S_JUMP    = 4'd5;
  localparam logic [3:0] S_ADDR    = 4'd6;
  localparam logic [3:0] S_STORE   = 4'd7;
  localparam logic [3:0] S_LOADOP  = 4'd8;
  localparam logic [3:0] S_ALU     = 4'd9;
  localparam logic [3:0] S_HALT    = 4'd10;

`ifdef NEANDER_CTRL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  localparam bit          WD_EN    = (ACK_TIMEOUT != 0);
  localparam logic [15:0] WD_LIMIT = WD_EN ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  logic [3:0]  state, state_nx;
  logic [3:0]  op_q;
  logic [3:0]  op_cur;
  logic [15:0] wd;
  logic        bus_err_q;
  logic        req_state, expire;

  logic is_sta, is_lda, is_add, is_or, is_and, is_not, is_sub;
  logic is_jmp, is_jn, is_jz, is_hlt, is_jump, is_mem_op;
  logic [2:0] ula_sel;

  logic pc_inc, pc_load, mar_sel, mar_load, rdm_load, ri_load;
  logic ac_load, nz_load, mem_req, mem_we, halted;
  logic [2:0] ula_op;

  // The opcode register is only valid after S_DECODE; decode itself looks at RI directly.
  assign op_cur = (state == S_DECODE) ? i_opcode : op_q;

  assign is_sta    = (op_cur == 4'h1);
  assign is_lda    = (op_cur == 4'h2);
  assign is_add    = (op_cur == 4'h3);
  assign is_or     = (op_cur == 4'h4);
  assign is_and    = (op_cur == 4'h5);
  assign is_not    = (op_cur == 4'h6);
  assign is_sub    = SUB_EN && (op_cur == 4'h7);
  assign is_jmp    = (op_cur == 4'h8);
  assign is_jn     = (op_cur == 4'h9);
  assign is_jz     = (op_cur == 4'hA);
  assign is_hlt    = (op_cur == 4'hF);
  assign is_jump   = is_jmp | is_jn | is_jz;
  assign is_mem_op = is_sta | is_lda | is_add | is_or | is_and | is_sub;

  always_comb begin
    ula_sel = 3'd0;
    if (is_add)      ula_sel = 3'd1;
    else if (is_or)  ula_sel = 3'd2;
    else if (is_and) ula_sel = 3'd3;
    else if (is_sub) ula_sel = 3'd5;
  end

  assign req_state = (state == S_FETCH_B) || (state == S_OPND) ||
                     (state == S_STORE)   || (state == S_LOADOP);
  assign expire    = WD_EN && req_state && !i_mem_ack && (wd == WD_LIMIT);

  always_comb begin
    state_nx = state;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_sel  = 1'b0;
    mar_load = 1'b0;
    rdm_load = 1'b0;
    ri_load  = 1'b0;
    ac_load  = 1'b0;
    nz_load  = 1'b0;
    ula_op   = 3'd0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH_A: begin
        mar_load = 1'b1;
        state_nx = S_FETCH_B;
      end
      S_FETCH_B: begin
        mem_req = 1'b1;
        if (expire) begin
          state_nx = S_HALT;
        end else if (i_mem_ack) begin
          rdm_load = 1'b1;
          pc_inc   = 1'b1;
          state_nx = S_FETCH_C;
        end
      end
      S_FETCH_C: begin
        ri_load  = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (is_not) begin
          ac_load  = 1'b1;
          nz_load  = 1'b1;
          ula_op   = 3'd4;
          state_nx = S_FETCH_A;
        end else if (is_hlt) begin
          state_nx = S_HALT;
        end else if ((is_jn && !i_n) || (is_jz && !i_z)) begin
          pc_inc   = 1'b1;
          state_nx = S_FETCH_A;
        end else if (is_jump || is_mem_op) begin
          mar_load = 1'b1;
          state_nx = S_OPND;
        end else begin
          state_nx = S_FETCH_A;
        end
      end
      S_OPND: begin
        mem_req = 1'b1;
        if (expire) begin
          state_nx = S_HALT;
        end else if (i_mem_ack) begin
          rdm_load = 1'b1;
          if (is_jump) begin
            state_nx = S_JUMP;
          end else begin
            pc_inc   = 1'b1;
            state_nx = S_ADDR;
          end
        end
      end
      S_JUMP: begin
        pc_load  = 1'b1;
        state_nx = S_FETCH_A;
      end
      S_ADDR: begin
        mar_load = 1'b1;
        mar_sel  = 1'b1;
        state_nx = is_sta ? S_STORE : S_LOADOP;
      end
      S_STORE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (expire)         state_nx = S_HALT;
        else if (i_mem_ack) state_nx = S_FETCH_A;
      end
      S_LOADOP: begin
        mem_req = 1'b1;
        if (expire) begin
          state_nx = S_HALT;
        end else if (i_mem_ack) begin
          rdm_load = 1'b1;
          state_nx = S_ALU;
        end
      end
      S_ALU: begin
        ac_load  = 1'b1;
        nz_load  = 1'b1;
        ula_op   = ula_sel;
        state_nx = S_FETCH_A;
      end
      S_HALT: begin
        halted = 1'b1;
        if (i_run) state_nx = S_FETCH_A;
      end
      default: state_nx = S_FETCH_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= S_FETCH_A;
      op_q      <= 4'h0;
      wd        <= 16'd0;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) op_q <= i_opcode;
      if (WD_EN && req_state && !i_mem_ack && !expire) wd <= wd + 16'd1;
      else                                              wd <= 16'd0;
      if (expire)                        bus_err_q <= 1'b1;
      else if (state == S_HALT && i_run) bus_err_q <= 1'b0;
    end
  end

  // Reset gates every output so an in-flight request drops in the same cycle.
  assign o_pc_inc   = i_rst & pc_inc;
  assign o_pc_load  = i_rst & pc_load;
  assign o_mar_sel  = i_rst & mar_sel;
  assign o_mar_load = i_rst & mar_load;
  assign o_rdm_load = i_rst & rdm_load;
  assign o_ri_load  = i_rst & ri_load;
  assign o_ac_load  = i_rst & ac_load;
  assign o_nz_load  = i_rst & nz_load;
  assign o_ula_op   = i_rst ? ula_op : 3'd0;
  assign o_mem_req  = i_rst & mem_req;
  assign o_mem_we   = i_rst & mem_we;
  assign o_halted   = i_rst & halted;
  assign o_bus_err  = i_rst & bus_err_q;

endmodule

// File: tb/tb_neander_control.sv
// tb/tb_neander_control.sv - self-checking bench for neander_control
module tb_neander_control;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [3:0] i_opcode = 4'h0;
  logic       i_n = 1'b0, i_z = 1'b0, i_mem_ack = 1'b0, i_run = 1'b0;
  logic       o_pc_inc, o_pc_load, o_mar_sel, o_mar_load, o_rdm_load, o_ri_load;
  logic       o_ac_load, o_nz_load, o_mem_req, o_mem_we, o_halted, o_bus_err;
  logic [2:0] o_ula_op;

  neander_control #(.ACK_TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_n(i_n), .i_z(i_z),
    .i_mem_ack(i_mem_ack), .i_run(i_run),
    .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load), .o_mar_sel(o_mar_sel),
    .o_mar_load(o_mar_load), .o_rdm_load(o_rdm_load), .o_ri_load(o_ri_load),
    .o_ac_load(o_ac_load), .o_nz_load(o_nz_load), .o_ula_op(o_ula_op),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_halted(o_halted), .o_bus_err(o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [14:0] PCI  = 15'h4000, PCL = 15'h2000, SEL = 15'h1000, MARL = 15'h0800;
  localparam logic [14:0] RDM  = 15'h0400, RI  = 15'h0200, AC  = 15'h0100, NZ   = 15'h0080;
  localparam logic [14:0] REQ  = 15'h0008, WE  = 15'h0004, HLTD = 15'h0002, BERR = 15'h0001;

  typedef struct packed {
    logic [14:0] exp;
    logic        ack;
    logic        run;
    logic [3:0]  op;
    logic        n;
    logic        z;
  } step_t;

  step_t      q[$];
  logic [3:0] cur_op;
  logic       cur_n, cur_z;
  int         checks = 0;
  int         passes = 0;
  int         step_no = 0;

  function automatic logic [14:0] ula(input logic [2:0] x);
    return {8'd0, x, 4'd0};
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'h3:    return 3'd1;
      4'h4:    return 3'd2;
      4'h5:    return 3'd3;
      4'h7:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit is_nop_op(input logic [3:0] op);
`ifdef NEANDER_CTRL_SUB_EN
    return (op == 4'h0) || (op >= 4'hB && op <= 4'hE);
`else
    return (op == 4'h0) || (op == 4'h7) || (op >= 4'hB && op <= 4'hE);
`endif
  endfunction

  function automatic logic [14:0] observed();
    return {o_pc_inc, o_pc_load, o_mar_sel, o_mar_load, o_rdm_load, o_ri_load,
            o_ac_load, o_nz_load, o_ula_op, o_mem_req, o_mem_we, o_halted, o_bus_err};
  endfunction

  // Inputs the design must ignore in a given cycle are randomised to prove they are ignored.
  task automatic push(input logic [14:0] e, input logic a, input logic r, input bit dec);
    step_t s;
    s.exp = e;
    s.ack = a;
    s.run = r;
    if (dec) begin
      s.op = cur_op; s.n = cur_n; s.z = cur_z;
    end else begin
      s.op = 4'($urandom % 16); s.n = 1'($urandom % 2); s.z = 1'($urandom % 2);
    end
    q.push_back(s);
  endtask

  task automatic idle(input logic [14:0] e);
    push(e, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
  endtask

  task automatic dec(input logic [14:0] e);
    push(e, 1'($urandom % 2), 1'($urandom % 2), 1'b1);
  endtask

  task automatic mem(input logic [14:0] e_wait, input logic [14:0] e_ack, input int w);
    repeat (w) push(e_wait, 1'b0, 1'($urandom % 2), 1'b0);
    push(e_ack, 1'b1, 1'($urandom % 2), 1'b0);
  endtask

  task automatic halt_cycles(input logic [14:0] berr, input int k);
    repeat (k) push(HLTD | berr, 1'($urandom % 2), 1'b0, 1'b0);
    push(HLTD | berr, 1'($urandom % 2), 1'b1, 1'b0);
  endtask

  task automatic instr(input logic [3:0] op, input logic n, input logic z,
                       input int w0, input int w1, input int w2, input int hk);
    bit jump;
    cur_op = op; cur_n = n; cur_z = z;
    idle(MARL);
    mem(REQ, REQ | RDM | PCI, w0);
    idle(RI);
    if (is_nop_op(op)) dec(15'h0);
    else if (op == 4'h6) dec(AC | NZ | ula(3'd4));
    else if (op == 4'hF) begin
      dec(15'h0);
      halt_cycles(15'h0, hk);
    end else if ((op == 4'h9 && !n) || (op == 4'hA && !z)) dec(PCI);
    else begin
      jump = (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
      dec(MARL);
      mem(REQ, REQ | RDM | (jump ? 15'h0 : PCI), w1);
      if (jump) idle(PCL);
      else begin
        idle(MARL | SEL);
        if (op == 4'h1) mem(REQ | WE, REQ | WE, w2);
        else begin
          mem(REQ, REQ | RDM, w2);
          idle(AC | NZ | ula(alu_code(op)));
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s step %0d: observed=%h expected=%h", tag, step_no, obs, exp);
  endtask

  task automatic run_q(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      i_mem_ack = s.ack; i_run = s.run; i_opcode = s.op; i_n = s.n; i_z = s.z;
      @(negedge i_clk);
      check(tag, observed(), s.exp);
      @(posedge i_clk);
      #1;
      step_no++;
    end
  endtask

  initial begin
    // Reset held for three edges with noisy inputs: everything must stay low.
    i_rst = 1'b0; i_mem_ack = 1'b1; i_run = 1'b1; i_opcode = 4'h2;
    repeat (3) begin
      @(negedge i_clk);
      check("reset", observed(), 15'h0);
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b1;

    instr(4'h0, 0, 0, 0, 0, 0, 0);  run_q("nop");
    instr(4'h2, 0, 0, 0, 2, 0, 0);  run_q("lda_wait");
    instr(4'hA, 0, 1, 0, 0, 0, 0);  run_q("jz_taken");
    instr(4'hA, 1, 0, 0, 0, 0, 0);  run_q("jz_not_taken");
    instr(4'h9, 1, 0, 1, 1, 0, 0);  run_q("jn_taken");
    instr(4'h9, 0, 1, 0, 0, 0, 0);  run_q("jn_not_taken");
    instr(4'h8, 0, 0, 0, 3, 0, 0);  run_q("jmp");
    instr(4'h3, 0, 0, 0, 0, 1, 0);  run_q("add");
    instr(4'h7, 0, 0, 0, 0, 0, 0);  run_q("op7");
    instr(4'h1, 0, 0, 2, 0, 3, 0);  run_q("sta");
    instr(4'h6, 0, 0, 0, 0, 0, 0);  run_q("not");
    instr(4'h5, 0, 0, 15, 15, 15, 0); run_q("ack_at_limit");
    instr(4'hF, 0, 0, 0, 0, 0, 50); run_q("hlt50");

    // STA whose store is never acknowledged: watchdog trips after 16 req cycles.
    cur_op = 4'h1; cur_n = 0; cur_z = 0;
    idle(MARL); mem(REQ, REQ | RDM | PCI, 0); idle(RI); dec(MARL);
    mem(REQ, REQ | RDM | PCI, 0); idle(MARL | SEL);
    repeat (16) push(REQ | WE, 1'b0, 1'($urandom % 2), 1'b0);
    halt_cycles(BERR, 2);
    instr(4'h0, 0, 0, 0, 0, 0, 0);
    run_q("sta_timeout");

    // Fetch never acknowledged.
    cur_op = 4'h0;
    idle(MARL);
    repeat (16) push(REQ, 1'b0, 1'($urandom % 2), 1'b0);
    halt_cycles(BERR, 1);
    instr(4'h4, 0, 0, 0, 0, 0, 0);
    run_q("fetch_timeout");

    for (int i = 0; i < 60; i++) begin
      instr(4'($urandom % 16), 1'($urandom % 2), 1'($urandom % 2),
            int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
            int'($urandom % 4));
      run_q("random");
    end

    // Reset arriving mid-fetch with an ack present: request and pc_inc must not appear.
    cur_op = 4'h0;
    idle(MARL);
    push(REQ, 1'b0, 1'b0, 1'b0);
    run_q("pre_mid_reset");
    i_rst = 1'b0; i_mem_ack = 1'b1; i_run = 1'b1;
    @(negedge i_clk);
    check("mid_reset", observed(), 15'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    instr(4'h2, 0, 0, 0, 0, 0, 0);
    run_q("after_mid_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
